// File: rtl/riscv_mul_pkg.sv
// rtl/riscv_mul_pkg.sv - operation encodings and shared helpers for the multiply pipe
package riscv_mul_pkg;

   localparam int MUL_XLEN_DEFAULT = 32;

   // RV funct3[1:0] of the M-extension multiply group
   typedef enum logic [1:0] {
      MUL_OP_MUL    = 2'b00,
      MUL_OP_MULH   = 2'b01,
      MUL_OP_MULHSU = 2'b10,
      MUL_OP_MULHU  = 2'b11
   } mul_op_e;

   // rs1 is treated as signed for MULH and MULHSU
   function automatic logic rs1_is_signed(input logic [1:0] op);
      return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
   endfunction

   // rs2 is treated as signed only for MULH
   function automatic logic rs2_is_signed(input logic [1:0] op);
      return (op == MUL_OP_MULH);
   endfunction

endpackage

// File: rtl/mul_core.sv
// rtl/mul_core.sv - combinational signed (XLEN+1)x(XLEN+1) multiplier, 2*XLEN-bit product
module mul_core #(
   parameter int XLEN = 32
) (
   input  logic signed [XLEN:0]     a,
   input  logic signed [XLEN:0]     b,
   output logic        [2*XLEN-1:0] p
);

   logic signed [2*XLEN-1:0] a_w;
   logic signed [2*XLEN-1:0] b_w;

   // Sign-extend to the product width so the multiply wraps at exactly 2*XLEN bits
   always_comb begin
      a_w = {{(XLEN-1){a[XLEN]}}, a};
      b_w = {{(XLEN-1){b[XLEN]}}, b};
      p   = a_w * b_w;
   end

endmodule

// File: rtl/mul_pipe.sv
// rtl/mul_pipe.sv - fully pipelined RV multiply unit with hold, flush and tag tracking
module mul_pipe
   import riscv_mul_pkg::*;
#(
   parameter int XLEN   = MUL_XLEN_DEFAULT,
   parameter int STAGES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_i,
   input  logic [1:0]      op_i,
   input  logic [4:0]      rd_idx_i,
   input  logic [XLEN-1:0] ra_operand,
   input  logic [XLEN-1:0] rb_operand,
   input  logic            hold,
   input  logic            flush,
   output logic            valid_o,
   output logic [4:0]      rd_idx_o,
   output logic [XLEN-1:0] wb_value,
   output logic            busy_o
);

   logic                     accept;
   logic signed [XLEN:0]     a_ext;
   logic signed [XLEN:0]     b_ext;
   logic        [2*XLEN-1:0] prod;
   logic        [XLEN-1:0]   result;

   logic                     st_valid [STAGES];
   logic        [4:0]        st_tag   [STAGES];
   logic        [XLEN-1:0]   st_data  [STAGES];

   // Issue qualification and operand extension; the product is selected before
   // the first register and retiming is left to synthesis
   always_comb begin
      accept = valid_i && !hold && !flush;
      a_ext  = $signed({rs1_is_signed(op_i) & ra_operand[XLEN-1], ra_operand});
      b_ext  = $signed({rs2_is_signed(op_i) & rb_operand[XLEN-1], rb_operand});
      result = (op_i == MUL_OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
   end

   mul_core #(.XLEN(XLEN)) u_core (
      .a (a_ext),
      .b (b_ext),
      .p (prod)
   );

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic            in_valid;
      logic [4:0]      in_tag;
      logic [XLEN-1:0] in_data;

      if (k == 0) begin : g_head
         assign in_valid = accept;
         assign in_tag   = rd_idx_i;
         assign in_data  = result;
      end else begin : g_body
         assign in_valid = st_valid[k-1];
         assign in_tag   = st_tag[k-1];
         assign in_data  = st_data[k-1];
      end

      // Stage register: flush kills, hold freezes, payload moves only with a valid op
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            st_valid[k] <= 1'b0;
            st_tag[k]   <= '0;
            st_data[k]  <= '0;
         end else if (flush) begin
            st_valid[k] <= 1'b0;
         end else if (!hold) begin
            st_valid[k] <= in_valid;
            if (in_valid) begin
               st_tag[k]  <= in_tag;
               st_data[k] <= in_data;
            end
         end
      end
   end

   // The last stage is the write-back port; its payload only changes on a completion
   always_comb begin
      valid_o  = st_valid[STAGES-1];
      rd_idx_o = st_tag[STAGES-1];
      wb_value = st_data[STAGES-1];
      busy_o   = 1'b0;
      for (int i = 0; i < STAGES; i++) begin
         busy_o = busy_o | st_valid[i];
      end
   end

endmodule

// File: tb/tb_mul_pipe.sv
// tb/tb_mul_pipe.sv - scoreboard bench for mul_pipe over several XLEN/STAGES configurations
module tb_mul_pipe;
   import riscv_mul_pkg::*;

   typedef struct {
      logic [63:0] val;
      logic [4:0]  tag;
      int          due;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        valid_i;
   logic [1:0]  op;
   logic [4:0]  tag;
   logic [63:0] ra;
   logic [63:0] rb;
   logic        hold;
   logic        flush;

   logic        v0;
   logic [31:0] wb0;
   logic [4:0]  tag0;
   logic        busy0;

   int total = 0;
   int bad   = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   // Reference: extend to true integers, multiply, then pick the low or high XLEN bits
   function automatic logic [63:0] ref_mul(input logic [1:0] o, input logic [63:0] a,
                                           input logic [63:0] b, input int xl);
      logic signed [131:0] ea, eb, p;
      logic        [131:0] mask;
      mask = (132'd1 << xl) - 132'd1;
      ea = a & mask;
      eb = b & mask;
      if ((o == 2'b01 || o == 2'b10) && a[xl-1]) ea = ea - (132'sd1 <<< xl);
      if (o == 2'b01 && b[xl-1]) eb = eb - (132'sd1 <<< xl);
      p = ea * eb;
      if (o == 2'b00) return 64'(p & mask);
      return 64'((p >>> xl) & mask);
   endfunction

   for (genvar g = 0; g < 5; g++) begin : g_inst
      localparam int XL = (g == 0) ? 32 : 64;
      localparam int ST = (g == 0) ? 2 : g;

      logic          valid_o;
      logic [4:0]    rd_idx_o;
      logic [XL-1:0] wb_value;
      logic          busy_o;

      exp_t        q[$];
      int          ucnt;
      logic [63:0] last;
      logic [4:0]  last_tag;

      mul_pipe #(.XLEN(XL), .STAGES(ST)) dut (
         .clk        (clk),
         .rst        (rst),
         .valid_i    (valid_i),
         .op_i       (op),
         .rd_idx_i   (tag),
         .ra_operand (ra[XL-1:0]),
         .rb_operand (rb[XL-1:0]),
         .hold       (hold),
         .flush      (flush),
         .valid_o    (valid_o),
         .rd_idx_o   (rd_idx_o),
         .wb_value   (wb_value),
         .busy_o     (busy_o)
      );

      if (g == 0) begin : g_tap
         assign v0    = valid_o;
         assign wb0   = wb_value;
         assign tag0  = rd_idx_o;
         assign busy0 = busy_o;
      end

      // Model: every accept is due after ST unheld edges; flush and reset empty the pipe
      initial begin
         ucnt     = 0;
         last     = '0;
         last_tag = '0;
         forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
               q.delete();
               last     = '0;
               last_tag = '0;
            end else begin
               if (flush) q.delete();
               else if (!hold && valid_i) q.push_back('{ref_mul(op, ra, rb, XL), tag, ucnt + ST});
               if (!hold) ucnt++;
            end
         end
      end

      // Monitor: compare whatever the DUT presents against the head of the queue
      initial begin
         forever begin
            @(negedge clk);
            if (!rst) begin
               chk($sformatf("i%0d_busy", g), 64'(busy_o), 64'(q.size() != 0));
               if (valid_o) begin
                  if (q.size() == 0) begin
                     chk($sformatf("i%0d_spurious_valid", g), 64'(valid_o), 64'd0);
                  end else begin
                     chk($sformatf("i%0d_latency", g), 64'(ucnt), 64'(q[0].due));
                     chk($sformatf("i%0d_wb", g), 64'(wb_value), q[0].val);
                     chk($sformatf("i%0d_tag", g), 64'(rd_idx_o), 64'(q[0].tag));
                     if (!hold || flush) begin
                        last     = q[0].val;
                        last_tag = q[0].tag;
                        void'(q.pop_front());
                     end
                  end
               end else begin
                  chk($sformatf("i%0d_wb_keep", g), 64'(wb_value), last);
                  chk($sformatf("i%0d_tag_keep", g), 64'(rd_idx_o), 64'(last_tag));
                  if (q.size() != 0 && q[0].due <= ucnt) begin
                     chk($sformatf("i%0d_missing_valid", g), 64'(valid_o), 64'd1);
                     void'(q.pop_front());
                  end
               end
            end
         end
      end
   end

   task automatic cyc(input logic v, input logic [1:0] o, input logic [63:0] a,
                      input logic [63:0] b, input logic [4:0] t, input logic h, input logic f);
      valid_i = v;
      op      = o;
      ra      = a;
      rb      = b;
      tag     = t;
      hold    = h;
      flush   = f;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0);
   endtask

   function automatic logic [63:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 64'hFFFF_FFFF_FFFF_FFFF;
         1:       return 64'h8000_0000_0000_0000;
         2:       return 64'h0000_0000_8000_0000;
         3:       return 64'h0000_0000_FFFF_FFFF;
         default: return {$urandom(), $urandom()};
      endcase
   endfunction

   logic [1:0]  d_op  [4];
   logic [63:0] d_a   [4];
   logic [63:0] d_b   [4];
   logic [31:0] d_exp [4];

   initial begin
      d_op[0] = MUL_OP_MULH;   d_a[0] = 64'h8000_0000; d_b[0] = 64'h8000_0000; d_exp[0] = 32'h4000_0000;
      d_op[1] = MUL_OP_MULHSU; d_a[1] = 64'hFFFF_FFFF; d_b[1] = 64'hFFFF_FFFF; d_exp[1] = 32'hFFFF_FFFF;
      d_op[2] = MUL_OP_MULHU;  d_a[2] = 64'hFFFF_FFFF; d_b[2] = 64'hFFFF_FFFF; d_exp[2] = 32'hFFFF_FFFE;
      d_op[3] = MUL_OP_MULH;   d_a[3] = 64'hFFFF_FFFF; d_b[3] = 64'h0000_0001; d_exp[3] = 32'hFFFF_FFFF;

      rst = 1'b1; valid_i = 1'b0; op = 2'b00; ra = '0; rb = '0; tag = '0; hold = 1'b0; flush = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_valid", 64'(v0), 64'd0);
      chk("reset_wb", 64'(wb0), 64'd0);
      chk("reset_tag", 64'(tag0), 64'd0);
      chk("reset_busy", 64'(busy0), 64'd0);

      // MUL all-ones squared, result two cycles later
      cyc(1'b1, MUL_OP_MUL, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd3, 1'b0, 1'b0);
      idle(1);
      chk("mul_ones_valid", 64'(v0), 64'd1);
      chk("mul_ones_wb", 64'(wb0), 64'h1);
      idle(6);

      // Back-to-back high-half variants
      for (int i = 0; i < 5; i++) begin
         if (i < 4) cyc(1'b1, d_op[i], d_a[i], d_b[i], 5'(i + 10), 1'b0, 1'b0);
         else       idle(1);
         if (i >= 1) begin
            chk($sformatf("b2b%0d_valid", i - 1), 64'(v0), 64'd1);
            chk($sformatf("b2b%0d_wb", i - 1), 64'(wb0), 64'(d_exp[i - 1]));
            chk($sformatf("b2b%0d_tag", i - 1), 64'(tag0), 64'(i + 9));
         end
      end
      idle(6);

      // Hold stretches latency by the held cycles
      cyc(1'b1, MUL_OP_MUL, 64'd5, 64'd6, 5'd7, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b1, MUL_OP_MUL, 64'd9, 64'd9, 5'd1, 1'b1, 1'b0);
      chk("hold_no_early_valid", 64'(v0), 64'd0);
      chk("hold_wb_stable", 64'(wb0), 64'hFFFF_FFFF);
      idle(1);
      chk("hold_valid", 64'(v0), 64'd1);
      chk("hold_tag", 64'(tag0), 64'd7);
      chk("hold_wb", 64'(wb0), 64'd30);
      idle(6);

      // Flush wins over hold and kills both in-flight ops
      cyc(1'b1, MUL_OP_MUL, 64'd3, 64'd4, 5'd2, 1'b0, 1'b0);
      cyc(1'b1, MUL_OP_MUL, 64'd5, 64'd4, 5'd3, 1'b1, 1'b1);
      chk("flush_busy", 64'(busy0), 64'd0);
      chk("flush_valid", 64'(v0), 64'd0);
      idle(4);
      chk("flush_no_late_valid", 64'(v0), 64'd0);

      // Asynchronous reset in the middle of a cycle
      cyc(1'b1, MUL_OP_MUL, 64'd7, 64'd7, 5'd4, 1'b0, 1'b0);
      valid_i = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 64'(v0), 64'd0);
      chk("arst_wb", 64'(wb0), 64'd0);
      chk("arst_tag", 64'(tag0), 64'd0);
      chk("arst_busy", 64'(busy0), 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      idle(1);
      cyc(1'b1, MUL_OP_MULHU, 64'hFFFF_FFFF, 64'h0000_0002, 5'd9, 1'b0, 1'b0);
      idle(1);
      chk("post_rst_valid", 64'(v0), 64'd1);
      chk("post_rst_wb", 64'(wb0), 64'd1);
      chk("post_rst_tag", 64'(tag0), 64'd9);
      idle(6);

      // Randomized traffic with stalls, flushes and occasional resets
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 299) == 0) begin
            valid_i = ($urandom_range(0, 1) == 1);
            op      = 2'($urandom());
            ra      = pick_operand();
            rb      = pick_operand();
            tag     = 5'($urandom());
            hold    = 1'b0;
            flush   = 1'b0;
            #1 rst = 1'b1;
            #1 rst = 1'b0;
            @(posedge clk);
            #1;
         end else begin
            cyc(($urandom_range(0, 9) < 7), 2'($urandom()), pick_operand(), pick_operand(),
                5'($urandom()), ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 3));
         end
      end
      idle(10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
